// File: rtl/ddr4_axi_rd_master.sv
// AXI4 read master: splits {address, beat count} requests into INCR bursts
// (max C_MAX_BURST_LEN beats, never crossing 4KB). One burst in flight at a
// time; read data is passed straight through to the datapath stream.
module ddr4_axi_rd_master #(
   parameter int unsigned C_AXI_ID_WIDTH   = 4,
   parameter int unsigned C_AXI_ADDR_WIDTH = 29,
   parameter int unsigned C_AXI_DATA_WIDTH = 64,
   parameter int unsigned C_MAX_BURST_LEN  = 64,
   parameter int unsigned C_AXI_ID         = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [C_AXI_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [23:0]                 req_beats_i,
   output logic [C_AXI_DATA_WIDTH-1:0] rd_data_o,
   output logic                        rd_valid_o,
   input  logic                        rd_ready_i,
   output logic                        rd_last_o,
   output logic                        done_o,
   output logic                        busy_o,
   output logic                        err_o,
   input  logic                        axi_arready_i,
   output logic [C_AXI_ID_WIDTH-1:0]   axi_arid_o,
   output logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr_o,
   output logic [7:0]                  axi_arlen_o,
   output logic [2:0]                  axi_arsize_o,
   output logic [1:0]                  axi_arburst_o,
   output logic                        axi_arlock_o,
   output logic [3:0]                  axi_arcache_o,
   output logic [2:0]                  axi_arprot_o,
   output logic                        axi_arvalid_o,
   input  logic [C_AXI_ID_WIDTH-1:0]   axi_rid_i,
   input  logic [1:0]                  axi_rresp_i,
   input  logic                        axi_rvalid_i,
   input  logic [C_AXI_DATA_WIDTH-1:0] axi_rdata_i,
   input  logic                        axi_rlast_i,
   output logic                        axi_rready_o
);

   localparam int unsigned AW = C_AXI_ADDR_WIDTH;
   localparam int unsigned SZ = $clog2(C_AXI_DATA_WIDTH / 8);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [23:0]   remaining_q, remaining_d;
   logic [8:0]    len_q, len_d;
   logic [8:0]    beat_cnt_q, beat_cnt_d;
   logic [AW-1:0] araddr_q;
   logic [7:0]    arlen_q;
   logic          arvalid_q;
   logic          err_q, err_d;
   logic          r_hs, last_beat, ar_hs;
   logic [12:0]   to_4k;
   logic [23:0]   len_full;
   logic [23:0]   left;
   logic          unused_ok;

   assign axi_arid_o    = C_AXI_ID_WIDTH'(C_AXI_ID);
   assign axi_arsize_o  = 3'(SZ);
   assign axi_arburst_o = 2'b01;
   assign axi_arlock_o  = 1'b0;
   assign axi_arcache_o = 4'b0011;
   assign axi_arprot_o  = 3'b000;
   assign axi_araddr_o  = araddr_q;
   assign axi_arlen_o   = arlen_q;
   assign axi_arvalid_o = arvalid_q;
   assign busy_o        = (state_q != S_IDLE);
   assign err_o         = err_q;
   assign ar_hs         = arvalid_q && axi_arready_i;

   // rid is meaningless with a single ID; low address bits are forced to zero
   assign unused_ok = ^{axi_rid_i, req_addr_i[SZ-1:0], len_full[23:9]};

   // Next-state, burst bookkeeping and datapath pass-through
   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      beat_cnt_d   = beat_cnt_q;
      err_d        = err_q;
      req_ready_o  = 1'b0;
      done_o       = 1'b0;
      rd_valid_o   = 1'b0;
      rd_last_o    = 1'b0;
      axi_rready_o = 1'b0;
      rd_data_o    = axi_rdata_i;
      r_hs         = 1'b0;
      last_beat    = (beat_cnt_q == len_q - 9'd1);
      left         = remaining_q - {15'd0, beat_cnt_q};
      case (state_q)
         S_IDLE: begin
            req_ready_o = !rst_i;
            if (req_valid_i) begin
               cur_addr_d  = {req_addr_i[AW-1:SZ], {SZ{1'b0}}};
               remaining_d = req_beats_i;
               state_d     = (req_beats_i != 24'd0) ? S_ADDR : S_DONE;
            end
         end
         S_ADDR: begin
            if (ar_hs) state_d = S_DATA;
         end
         S_DATA: begin
            rd_valid_o   = axi_rvalid_i;
            axi_rready_o = rd_ready_i;
            rd_last_o    = axi_rvalid_i && (left == 24'd1);
            r_hs         = axi_rvalid_i && rd_ready_i;
            if (r_hs) begin
               // burst end is decided by our own counter, never by rlast
               if ((axi_rresp_i != 2'b00) || (axi_rlast_i != last_beat)) err_d = 1'b1;
               if (last_beat) begin
                  beat_cnt_d  = 9'd0;
                  remaining_d = remaining_q - {15'd0, len_q};
                  cur_addr_d  = cur_addr_q + (AW'(len_q) << SZ);
                  state_d     = (remaining_d == 24'd0) ? S_DONE : S_ADDR;
               end else begin
                  beat_cnt_d = beat_cnt_q + 9'd1;
               end
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // next burst length: min(remaining, max burst, beats left in this 4KB page)
      to_4k    = (13'h1000 - {1'b0, cur_addr_d[11:0]}) >> SZ;
      len_full = remaining_d;
      if (len_full > 24'(C_MAX_BURST_LEN)) len_full = 24'(C_MAX_BURST_LEN);
      if (len_full > {11'd0, to_4k}) len_full = {11'd0, to_4k};
      len_d = len_full[8:0];
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Address/count registers; AR fields loaded on ADDR entry and held until accepted
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_addr_q  <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arvalid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
         if ((state_d == S_ADDR) && (state_q != S_ADDR)) begin
            arvalid_q <= 1'b1;
            araddr_q  <= cur_addr_d;
            arlen_q   <= 8'(len_d - 9'd1);
            len_q     <= len_d;
         end else if (ar_hs) begin
            arvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ddr4_axi_rd_master.sv
// Directed bench for ddr4_axi_rd_master with a memory-backed AXI slave model,
// an AR expectation queue and a read-data scoreboard.
module tb_ddr4_axi_rd_master;

   typedef struct { logic [28:0] addr; logic [7:0] len; } ar_t;
   typedef struct { logic [63:0] data; logic last; } rx_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [28:0] req_addr = '0;
   logic [23:0] req_beats = '0;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic        rd_last, done, busy, err;
   logic        axi_arready = 1'b0;
   logic [3:0]  axi_arid;
   logic [28:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic        axi_arlock;
   logic [3:0]  axi_arcache;
   logic [2:0]  axi_arprot;
   logic        axi_arvalid;
   logic [3:0]  axi_rid = '0;
   logic [1:0]  axi_rresp = '0;
   logic        axi_rvalid = 1'b0;
   logic [63:0] axi_rdata = '0;
   logic        axi_rlast = 1'b0;
   logic        axi_rready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_hs_cyc = -1;
   int beats_rx = 0;

   // slave / bench control
   bit          mon_en = 0;
   bit          rdy_toggle = 0;
   int          ar_delay = 0;
   int          inj_beat = -1;
   bit          exp_err = 0;
   bit          r_active = 0;
   logic [28:0] r_addr = '0;
   logic [7:0]  r_len = '0;
   int          r_cnt = 0;
   int          arv_cnt = 0;
   logic [28:0] hold_addr = '0;
   logic [7:0]  hold_len = '0;

   ar_t ar_q[$];
   rx_t rx_q[$];

   ddr4_axi_rd_master dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_beats_i(req_beats),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
      .rd_last_o(rd_last), .done_o(done), .busy_o(busy), .err_o(err),
      .axi_arready_i(axi_arready), .axi_arid_o(axi_arid), .axi_araddr_o(axi_araddr),
      .axi_arlen_o(axi_arlen), .axi_arsize_o(axi_arsize), .axi_arburst_o(axi_arburst),
      .axi_arlock_o(axi_arlock), .axi_arcache_o(axi_arcache), .axi_arprot_o(axi_arprot),
      .axi_arvalid_o(axi_arvalid),
      .axi_rid_i(axi_rid), .axi_rresp_i(axi_rresp), .axi_rvalid_i(axi_rvalid),
      .axi_rdata_i(axi_rdata), .axi_rlast_i(axi_rlast), .axi_rready_o(axi_rready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // memory contents: address in the low word, its complement in the high word
   function automatic logic [63:0] pat(input logic [28:0] a);
      return {~{3'b000, a}, {3'b000, a}};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_ar(input logic [28:0] a, input logic [7:0] l);
      ar_t e;
      e.addr = a;
      e.len  = l;
      ar_q.push_back(e);
   endtask

   // called at posedge+2; returns at posedge+2 after the accepting edge
   task automatic send_req(input logic [28:0] a, input int n);
      logic [28:0] al;
      bit ok;
      al = {a[28:3], 3'b000};
      for (int i = 0; i < n; i++) begin
         rx_t e;
         e.data = pat(al + 29'(i) * 29'd8);
         e.last = (i == n - 1);
         rx_q.push_back(e);
      end
      req_addr  = a;
      req_beats = 24'(n);
      req_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (req_ready) ok = 1;
         @(posedge clk); #2;
      end
      req_valid = 1'b0;
      chk("req_accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         if (done) seen = 1;
         else begin @(posedge clk); #2; end
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) chk({tag, "_done_cycle"}, 64'(cyc), 64'(last_hs_cyc));
      @(posedge clk); #2;
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_rx_left"}, 64'(rx_q.size()), 64'd0);
      chk({tag, "_ar_left"}, 64'(ar_q.size()), 64'd0);
   endtask

   // AXI slave model + monitor: drive on negedge, observe 1 time unit later
   always @(negedge clk) begin
      rx_t e;
      ar_t a;
      axi_arready = (arv_cnt >= ar_delay);
      if (r_active) begin
         axi_rvalid = 1'b1;
         axi_rdata  = pat(r_addr + 29'(r_cnt) * 29'd8);
         axi_rlast  = (r_cnt == int'(r_len));
         axi_rresp  = (inj_beat == r_cnt) ? 2'b10 : 2'b00;
      end else begin
         axi_rvalid = 1'b0;
         axi_rdata  = '0;
         axi_rlast  = 1'b0;
         axi_rresp  = 2'b00;
      end
      rd_ready = rdy_toggle ? ~rd_ready : 1'b1;
      #1;
      if (mon_en) begin
         chk("err", 64'(err), 64'(exp_err));
         if (!rst) begin
            if (r_active) begin
               chk("rready_eq_rd_ready", 64'(axi_rready), 64'(rd_ready));
               chk("rd_valid_pass", 64'(rd_valid), 64'(axi_rvalid));
            end else begin
               chk("rd_valid_idle", 64'(rd_valid), 64'd0);
            end
            if (r_active && axi_rvalid && axi_rready) begin
               if (rx_q.size() == 0) chk("rx_unexpected", 64'd1, 64'd0);
               else begin
                  e = rx_q.pop_front();
                  chk("rd_data", rd_data, e.data);
                  chk("rd_last", 64'(rd_last), 64'(e.last));
                  if (e.last) last_hs_cyc = cyc + 1;
               end
               if (axi_rresp != 2'b00) exp_err = 1;
               beats_rx++;
               if (axi_rlast) r_active = 0;
               else r_cnt++;
            end
            if (axi_arvalid) begin
               if (axi_arready) begin
                  if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                  else begin
                     a = ar_q.pop_front();
                     chk("araddr", 64'(axi_araddr), 64'(a.addr));
                     chk("arlen", 64'(axi_arlen), 64'(a.len));
                  end
                  chk("arsize", 64'(axi_arsize), 64'd3);
                  chk("arburst", 64'(axi_arburst), 64'd1);
                  chk("ar_static", 64'({axi_arid, axi_arlock, axi_arcache, axi_arprot}),
                      64'({4'd0, 1'b0, 4'b0011, 3'b000}));
                  r_active = 1;
                  r_addr   = axi_araddr;
                  r_len    = axi_arlen;
                  r_cnt    = 0;
                  arv_cnt  = 0;
               end else begin
                  if (arv_cnt == 0) begin
                     hold_addr = axi_araddr;
                     hold_len  = axi_arlen;
                  end else begin
                     chk("araddr_stable", 64'(axi_araddr), 64'(hold_addr));
                     chk("arlen_stable", 64'(axi_arlen), 64'(hold_len));
                  end
                  arv_cnt++;
               end
            end
         end else begin
            r_active = 0;
            arv_cnt  = 0;
            exp_err  = 0;
         end
      end
   end

   initial begin
      int base;
      bit hit;
      // reset
      repeat (3) @(posedge clk);
      #2;
      chk("req_ready_in_rst", 64'(req_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
      chk("rst_rready", 64'(axi_rready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_last", 64'(rd_last), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      exp_err = 0;
      mon_en  = 1;
      @(posedge clk); #2;

      // 1: single burst
      push_ar(29'h0, 8'd15);
      send_req(29'h0, 16);
      wait_done("t1");

      // 2: 4KB split
      push_ar(29'hF80, 8'd15);
      push_ar(29'h1000, 8'd47);
      send_req(29'hF80, 64);
      wait_done("t2");

      // 3: max-burst split
      push_ar(29'h000, 8'd63);
      push_ar(29'h200, 8'd63);
      push_ar(29'h400, 8'd21);
      send_req(29'h0, 150);
      wait_done("t3");

      // 4: backpressure on both channels
      ar_delay   = 3;
      rdy_toggle = 1;
      push_ar(29'h100, 8'd31);
      send_req(29'h100, 32);
      wait_done("t4");
      ar_delay   = 0;
      rdy_toggle = 0;

      // 5: error response on beat 3 of 8, unaligned start address
      inj_beat = 2;
      push_ar(29'h2000, 8'd7);
      send_req(29'h2003, 8);
      wait_done("t5");
      inj_beat = -1;
      repeat (3) @(posedge clk);
      #2;
      chk("t5_err_sticky", 64'(err), 64'd1);

      // 6: reset during beat 5 of 16
      push_ar(29'h3000, 8'd15);
      base = beats_rx;
      send_req(29'h3000, 16);
      hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
         if (beats_rx - base >= 4) hit = 1;
         else begin @(posedge clk); #2; end
      end
      chk("t6_beats_seen", 64'(hit), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_req_ready_in_rst", 64'(req_ready), 64'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      rx_q.delete();
      ar_q.delete();
      #1;
      chk("t6_arvalid", 64'(axi_arvalid), 64'd0);
      chk("t6_rready", 64'(axi_rready), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_err_cleared", 64'(err), 64'd0);
      @(posedge clk); #2;

      // zero-beat request: no AR, done one cycle after accept
      send_req(29'h40, 0);
      chk("t6z_done", 64'(done), 64'd1);
      chk("t6z_busy", 64'(busy), 64'd1);
      @(posedge clk); #2;
      chk("t6z_done_pulse", 64'(done), 64'd0);
      chk("t6z_idle", 64'(busy), 64'd0);
      chk("t6z_req_ready", 64'(req_ready), 64'd1);
      repeat (5) @(posedge clk);
      #2;
      chk("end_ar_left", 64'(ar_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
